// File: rtl/symbol_scheduler.sv
// Frames a stream of 5-bit payload symbols for the modulator: preamble, payload and guard,
// with one symbol vector loaded per symbol period and handshaked upstream consumption.
module symbol_scheduler #(
    parameter int         SAMPLES_PER_SYMBOL = 10,
    parameter int         COUNTER_SIZE       = 4,
    parameter int         PREAMBLE_LEN       = 4,
    parameter int         GUARD_LEN          = 2,
    parameter logic [4:0] PRE_A              = 5'h15,
    parameter logic [4:0] PRE_B              = 5'h0A,
    parameter logic [4:0] IDLE_SYM           = 5'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        sym_valid,
    input  logic [4:0]  sym_data,
    input  logic        sym_last,
    output logic        sym_ready,
    output logic [1:0]  x0,
    output logic [1:0]  x1,
    output logic        x2,
    output logic        sym_strobe,
    output logic        frame_active,
    output logic        underrun,
    input  logic        clr_underrun,
    output logic [15:0] frame_count
);

    localparam int PIDX_W = $clog2(PREAMBLE_LEN + 1);
    localparam int GIDX_W = $clog2(GUARD_LEN + 1);

    localparam logic [COUNTER_SIZE-1:0] CNT_LAST  = COUNTER_SIZE'(SAMPLES_PER_SYMBOL - 1);
    localparam logic [PIDX_W-1:0]       PIDX_LAST = PIDX_W'(PREAMBLE_LEN);
    localparam logic [GIDX_W-1:0]       GIDX_LAST = GIDX_W'(GUARD_LEN);
    localparam logic [PIDX_W-1:0]       PIDX_ONE  = PIDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREAMBLE = 2'd1,
        S_PAYLOAD  = 2'd2,
        S_GUARD    = 2'd3
    } state_t;

    state_t                  state;
    logic [COUNTER_SIZE-1:0] cnt;
    logic [PIDX_W-1:0]       pidx;
    logic [GIDX_W-1:0]       gidx;
    logic [GIDX_W-1:0]       gidx_next;
    logic [4:0]              sym_q;
    logic                    boundary;
    logic                    payload_slot;
    logic                    take;
    logic                    starve;

    // Preamble alternates A/B starting with A at index 0.
    function automatic logic [4:0] preamble_sym(input logic [PIDX_W-1:0] idx);
        return idx[0] ? PRE_B : PRE_A;
    endfunction

    assign boundary     = (cnt == CNT_LAST);
    assign payload_slot = (state == S_PAYLOAD) ||
                          ((state == S_PREAMBLE) && (pidx == PIDX_LAST));
    assign sym_ready    = boundary && payload_slot;
    assign take         = sym_ready && sym_valid;
    assign starve       = sym_ready && !sym_valid;
    assign frame_active = (state == S_PREAMBLE) || (state == S_PAYLOAD);
    assign gidx_next    = gidx + 1'b1;

    assign x0 = sym_q[4:3];
    assign x1 = sym_q[2:1];
    assign x2 = sym_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            sym_strobe <= 1'b0;
        end else begin
            sym_strobe <= boundary;
            if (boundary) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Symbol vector and frame sequencing advance only on the load edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pidx  <= '0;
            gidx  <= '0;
            sym_q <= '0;
        end else if (boundary) begin
            if (payload_slot) begin
                pidx <= '0;
                gidx <= '0;
                if (sym_valid) begin
                    sym_q <= sym_data;
                    if (sym_last) begin
                        state <= S_GUARD;
                    end else begin
                        state <= S_PAYLOAD;
                    end
                end else begin
                    sym_q <= IDLE_SYM;
                    state <= S_GUARD;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        gidx <= '0;
                        if (en && sym_valid) begin
                            sym_q <= PRE_A;
                            pidx  <= PIDX_ONE;
                            state <= S_PREAMBLE;
                        end else begin
                            sym_q <= IDLE_SYM;
                            pidx  <= '0;
                        end
                    end
                    S_PREAMBLE: begin
                        sym_q <= preamble_sym(pidx);
                        pidx  <= pidx + 1'b1;
                    end
                    S_GUARD: begin
                        sym_q <= IDLE_SYM;
                        if (gidx_next == GIDX_LAST) begin
                            gidx  <= '0;
                            pidx  <= '0;
                            state <= S_IDLE;
                        end else begin
                            gidx <= gidx_next;
                        end
                    end
                    default: begin
                        sym_q <= IDLE_SYM;
                        pidx  <= '0;
                        gidx  <= '0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count <= '0;
        end else if (take && sym_last) begin
            frame_count <= frame_count + 16'd1;
        end
    end

    // A fresh underrun outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun <= 1'b0;
        end else if (starve) begin
            underrun <= 1'b1;
        end else if (clr_underrun) begin
            underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_symbol_scheduler.sv
// Bench for symbol_scheduler: frame-level reference model checked every cycle, directed
// scenarios with literal expectations, then randomized upstream traffic.
module tb_symbol_scheduler;

    localparam int         SPS      = 10;
    localparam int         PLEN     = 4;
    localparam int         GLEN     = 2;
    localparam logic [4:0] PRE_A    = 5'h15;
    localparam logic [4:0] PRE_B    = 5'h0A;
    localparam logic [4:0] IDLE_SYM = 5'h00;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        sym_valid;
    logic [4:0]  sym_data;
    logic        sym_last;
    logic        sym_ready;
    logic [1:0]  x0;
    logic [1:0]  x1;
    logic        x2;
    logic        sym_strobe;
    logic        frame_active;
    logic        underrun;
    logic        clr_underrun;
    logic [15:0] frame_count;

    symbol_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .sym_valid    (sym_valid),
        .sym_data     (sym_data),
        .sym_last     (sym_last),
        .sym_ready    (sym_ready),
        .x0           (x0),
        .x1           (x1),
        .x2           (x2),
        .sym_strobe   (sym_strobe),
        .frame_active (frame_active),
        .underrun     (underrun),
        .clr_underrun (clr_underrun),
        .frame_count  (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the frame is a sequence of symbol slots; after a frame ends
    // the remaining guard slots are counted down.
    int          m_cnt;
    bit          m_in_frame;
    int          m_sent;
    int          m_guard_left;
    logic [4:0]  m_x;
    bit          m_strobe;
    bit          m_underrun;
    logic [15:0] m_fc;

    task automatic model_reset();
        m_cnt        = 0;
        m_in_frame   = 0;
        m_sent       = 0;
        m_guard_left = 0;
        m_x          = 5'h00;
        m_strobe     = 0;
        m_underrun   = 0;
        m_fc         = 16'h0000;
    endtask

    task automatic model_step();
        bit bnd;
        bit set_u;
        bnd   = (m_cnt == SPS - 1);
        set_u = 0;
        if (bnd) begin
            if (!m_in_frame) begin
                if (en && sym_valid) begin
                    m_x        = PRE_A;
                    m_in_frame = 1;
                    m_sent     = 1;
                end else begin
                    m_x = IDLE_SYM;
                end
            end else if (m_guard_left > 0) begin
                m_x = IDLE_SYM;
                m_guard_left--;
                if (m_guard_left == 0) m_in_frame = 0;
            end else if (m_sent < PLEN) begin
                m_x = (m_sent % 2 == 0) ? PRE_A : PRE_B;
                m_sent++;
            end else if (sym_valid) begin
                m_x = sym_data;
                if (sym_last) begin
                    m_guard_left = GLEN;
                    m_fc         = m_fc + 16'd1;
                end
            end else begin
                m_x          = IDLE_SYM;
                set_u        = 1;
                m_guard_left = GLEN;
            end
        end
        if (set_u) m_underrun = 1;
        else if (clr_underrun) m_underrun = 0;
        m_strobe = bnd;
        m_cnt    = (m_cnt + 1) % SPS;
    endtask

    initial begin
        bit exp_ready;
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            exp_ready = rst_n && (m_cnt == SPS - 1) && m_in_frame &&
                        (m_guard_left == 0) && (m_sent == PLEN);
            check("x_vec", {27'd0, x0, x1, x2}, {27'd0, m_x});
            check("sym_strobe", sym_strobe, m_strobe);
            check("frame_active", frame_active, m_in_frame && (m_guard_left == 0));
            check("underrun", underrun, m_underrun);
            check("frame_count", frame_count, m_fc);
            check("sym_ready", sym_ready, exp_ready);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Upstream source: items are {last, data}; the head is presented while src_on.
    logic [5:0] up_q[$];
    bit         src_on;
    int         ready_cnt;
    int         strobe_cnt;
    int         first_strobe;
    int         cyc;
    logic [4:0] cap_q[$];

    task automatic drive_src();
        if (src_on && up_q.size() > 0) begin
            sym_valid = 1'b1;
            {sym_last, sym_data} = up_q[0];
        end else begin
            sym_valid = 1'b0;
            sym_last  = 1'($urandom);
            sym_data  = 5'($urandom);
        end
    endtask

    task automatic clear_obs();
        ready_cnt    = 0;
        strobe_cnt   = 0;
        first_strobe = -1;
        cyc          = 0;
        cap_q.delete();
    endtask

    task automatic step();
        bit xfer;
        @(negedge clk);
        xfer = sym_valid && sym_ready;
        if (sym_ready) ready_cnt++;
        if (sym_strobe) begin
            cap_q.push_back({x0, x1, x2});
            strobe_cnt++;
            if (first_strobe < 0) first_strobe = cyc;
        end
        cyc++;
        @(posedge clk);
        #2;
        if (xfer && up_q.size() > 0) void'(up_q.pop_front());
        drive_src();
    endtask

    initial begin
        logic [4:0] exp_seq [9];
        int         idx;
        int         nz;
        bit         started;
        bit         found;
        int         n;

        exp_seq = '{5'h15, 5'h0A, 5'h15, 5'h0A, 5'h1F, 5'h06, 5'h11, 5'h00, 5'h00};
        rst_n = 1'b0; en = 1'b0; clr_underrun = 1'b0; src_on = 1'b1;
        sym_valid = 1'b0; sym_data = 5'h00; sym_last = 1'b0;
        clear_obs();
        repeat (3) @(posedge clk);
        #1;
        check("reset_x", {x0, x1, x2}, 5'h00);
        check("reset_ready", sym_ready, 1'b0);
        check("reset_fc", frame_count, 16'h0000);
        #1;
        rst_n = 1'b1;

        // Idle with valid data but no enable.
        up_q.push_back({1'b0, 5'h1B});
        drive_src();
        clear_obs();
        repeat (100) step();
        check("idle_first_strobe", first_strobe, 10);
        check("idle_strobe_count", strobe_cnt, 9);
        check("idle_ready_count", ready_cnt, 0);
        nz = 0;
        foreach (cap_q[i]) if (cap_q[i] != 5'h00) nz++;
        check("idle_nonzero_syms", nz, 0);
        up_q.delete();
        drive_src();

        // Three-symbol frame.
        up_q.push_back({1'b0, 5'h1F});
        up_q.push_back({1'b0, 5'h06});
        up_q.push_back({1'b1, 5'h11});
        en = 1'b1;
        drive_src();
        clear_obs();
        repeat (130) step();
        en = 1'b0;
        idx = -1;
        foreach (cap_q[i]) if (idx < 0 && cap_q[i] == 5'h15) idx = i;
        if (idx < 0 || cap_q.size() < idx + 9) begin
            check("frame_seq_found", 0, 1);
        end else begin
            for (int k = 0; k < 9; k++) check($sformatf("frame_seq[%0d]", k), cap_q[idx + k], exp_seq[k]);
        end
        check("frame_ready_count", ready_cnt, 3);
        check("frame_fc", frame_count, 16'd1);

        // Underrun after one payload symbol; en drops mid-frame.
        up_q.push_back({1'b0, 5'h05});
        en = 1'b1;
        drive_src();
        repeat (20) step();
        en = 1'b0;
        repeat (80) step();
        check("underrun_set", underrun, 1'b1);
        check("underrun_fc", frame_count, 16'd1);
        clr_underrun = 1'b1;
        step();
        clr_underrun = 1'b0;
        check("underrun_cleared", underrun, 1'b0);

        // Clear held through the underrun boundary: the set still wins.
        up_q.push_back({1'b0, 5'h07});
        en = 1'b1;
        clr_underrun = 1'b1;
        drive_src();
        started = 0;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (frame_active) started = 1;
            else if (started) begin
                found = 1;
                check("set_beats_clear", underrun, 1'b1);
            end
        end
        if (!found) check("set_beats_clear_timeout", 0, 1);
        clr_underrun = 1'b0;
        en = 1'b0;
        repeat (40) step();

        // Reset in the middle of the payload, at cnt==5.
        for (int k = 0; k < 4; k++) up_q.push_back({1'b0, 5'($urandom)});
        en = 1'b1;
        drive_src();
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            step();
            if (m_in_frame && m_guard_left == 0 && m_sent == PLEN && up_q.size() < 4 && m_cnt == 5)
                found = 1;
        end
        if (!found) check("mid_payload_timeout", 0, 1);
        rst_n = 1'b0;
        #1;
        check("rst_x", {x0, x1, x2}, 5'h00);
        check("rst_active", frame_active, 1'b0);
        check("rst_fc", frame_count, 16'h0000);
        check("rst_strobe", sym_strobe, 1'b0);
        repeat (2) step();
        rst_n = 1'b1;
        up_q.delete();
        up_q.push_back({1'b1, 5'h09});
        drive_src();
        clear_obs();
        repeat (60) step();
        idx = -1;
        foreach (cap_q[i]) if (idx < 0 && cap_q[i] != 5'h00) idx = i;
        check("post_reset_first_sym", (idx < 0) ? 5'h1F : cap_q[idx], 5'h15);
        repeat (40) step();
        check("post_reset_fc", frame_count, 16'd1);
        en = 1'b0;

        // frame_count wrap.
        force dut.frame_count = 16'hFFFF;
        m_fc = 16'hFFFF;
        #1;
        release dut.frame_count;
        up_q.push_back({1'b0, 5'h0C});
        up_q.push_back({1'b1, 5'h03});
        en = 1'b1;
        drive_src();
        repeat (130) step();
        check("fc_wrap", frame_count, 16'h0000);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step();
            en           = ($urandom % 2) == 0;
            clr_underrun = ($urandom % 20) == 0;
            src_on       = ($urandom % 10) != 0;
            if (up_q.size() == 0 && ($urandom % 4) == 0) begin
                n = 1 + ($urandom % 5);
                for (int k = 0; k < n; k++)
                    up_q.push_back({(k == n - 1) || (($urandom % 8) == 0), 5'($urandom)});
            end
            drive_src();
        end
        en = 1'b0;
        clr_underrun = 1'b0;
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
